// File: rtl/fetch_unit.sv
// PC register and instruction-fetch sequencer for the 19-bit single-cycle core.
// Walks IDLE -> FETCH -> WAIT -> EXEC, holding the fetched word for the controller.
module fetch_unit #(
  parameter int          XLEN     = 19,
  parameter logic [18:0] RESET_PC = 19'd0,
  parameter int          TIMEOUT  = 15,
  parameter logic [4:0]  HALT_OP  = 5'b11111
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pc_target,
  input  logic            stall,
  output logic [XLEN-1:0] instr,
  output logic [4:0]      op,
  output logic [4:0]      funct5,
  output logic            f7b5,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus1,
  output logic            halted,
  output logic            fetch_err,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC,
    HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] waitCount;

  assign imem_addr = pc;
  assign pc_plus1  = pc + XLEN'(1);
  assign op        = instr[4:0];
  assign funct5    = instr[13:9];
  assign f7b5      = instr[XLEN-1];

  // imem_req and instr_valid are registered alongside the state they belong to,
  // so each branch sets them for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= XLEN'(RESET_PC);
      instr       <= '0;
      instret     <= '0;
      waitCount   <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          state     <= WAIT;
          waitCount <= '0;
        end
        WAIT: begin
          if (imem_valid) begin
            instr       <= imem_rdata;
            waitCount   <= '0;
            state       <= EXEC;
            instr_valid <= 1'b1;
          end else if (waitCount == WAIT_LAST) begin
            fetch_err <= 1'b1;
            halted    <= 1'b1;
            waitCount <= '0;
            state     <= HALT;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        EXEC: begin
          if (stall) begin
            instr_valid <= 1'b1;
          end else begin
            pc      <= pcsrc ? pc_target : pc_plus1;
            instret <= instret + 32'd1;
            // The halt instruction still retires and still moves the PC.
            if (op == HALT_OP) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of instructions driven through a simple
// memory model, followed by hand-written reset, timeout and halt sequences.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        imem_valid;
  logic        pcsrc;
  logic [18:0] pc_target;
  logic        stall;
  logic [18:0] instr;
  logic [4:0]  op;
  logic [4:0]  funct5;
  logic        f7b5;
  logic        instr_valid;
  logic [18:0] pc;
  logic [18:0] pc_plus1;
  logic        halted;
  logic        fetch_err;
  logic [31:0] instret;

  int checkCount;
  int passCount;
  int cyc;
  int lastReq;

  typedef struct {
    int          lat;
    logic [18:0] rdata;
    logic        pcsrc;
    logic [18:0] target;
    int          stalls;
    bit          spur;
    int          gap;
    logic [18:0] expAddr;
    logic [4:0]  expOp;
    logic [4:0]  expF5;
    logic        expF7;
    logic [18:0] expPcPlus1;
    logic [18:0] expPc;
    logic [31:0] expRet;
    logic        expHalt;
  } vec_t;

  vec_t vecs[8];

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pcsrc      (pcsrc),
    .pc_target  (pc_target),
    .stall      (stall),
    .instr      (instr),
    .op         (op),
    .funct5     (funct5),
    .f7b5       (f7b5),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus1   (pc_plus1),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Runs one instruction: waits for the request, answers after v.lat cycles,
  // then holds EXEC for v.stalls cycles before letting it retire.
  task automatic applyStimulus(input vec_t v);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_seen", {31'd0, imem_req}, 32'd1);
    checkOutput("imem_addr", {13'd0, imem_addr}, {13'd0, v.expAddr});
    checkOutput("req_no_valid", {31'd0, instr_valid}, 32'd0);
    if (v.gap != 0) checkOutput("req_gap", cyc - lastReq, v.gap);
    lastReq = cyc;
    repeat (v.lat) @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = v.rdata;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = '0;
    checkOutput("instr_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("exec_no_req", {31'd0, imem_req}, 32'd0);
    checkOutput("instr", {13'd0, instr}, {13'd0, v.rdata});
    checkOutput("op", {27'd0, op}, {27'd0, v.expOp});
    checkOutput("funct5", {27'd0, funct5}, {27'd0, v.expF5});
    checkOutput("f7b5", {31'd0, f7b5}, {31'd0, v.expF7});
    checkOutput("pc_plus1", {13'd0, pc_plus1}, {13'd0, v.expPcPlus1});
    pcsrc     = v.pcsrc;
    pc_target = v.target;
    stall     = (v.stalls > 0);
    for (int i = 0; i < v.stalls; i++) begin
      if (v.spur && i == 0) begin
        imem_valid = 1'b1;
        imem_rdata = 19'h2AAAA;
      end
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = '0;
      if (i == v.stalls - 1) stall = 1'b0;
      checkOutput("stall_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("stall_no_req", {31'd0, imem_req}, 32'd0);
      checkOutput("stall_pc", {13'd0, pc}, {13'd0, v.expAddr});
      checkOutput("stall_instr", {13'd0, instr}, {13'd0, v.rdata});
      checkOutput("stall_instret", instret, v.expRet - 32'd1);
    end
    @(negedge clk);
    pcsrc     = 1'b0;
    pc_target = '0;
    checkOutput("pc_next", {13'd0, pc}, {13'd0, v.expPc});
    checkOutput("instret", instret, v.expRet);
    checkOutput("halted", {31'd0, halted}, {31'd0, v.expHalt});
    checkOutput("valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    int reqSeen;
    vec_t one;
    checkCount = 0;
    passCount  = 0;
    lastReq    = 0;
    reset      = 1'b1;
    imem_rdata = '0;
    imem_valid = 1'b0;
    pcsrc      = 1'b0;
    pc_target  = '0;
    stall      = 1'b0;

    //          lat rdata     pcsrc target   stl spur gap addr     op  f5  f7 pc+1     pc       ret halt
    vecs[0] = '{1, 19'h40203, 1'b0, 19'h0,     0, 0, 0, 19'h00000, 5'd3,  5'd1,  1'b1, 19'h00001, 19'h00001, 32'd1, 1'b0};
    vecs[1] = '{1, 19'h03C05, 1'b0, 19'h0,     0, 0, 3, 19'h00001, 5'd5,  5'd30, 1'b0, 19'h00002, 19'h00002, 32'd2, 1'b0};
    vecs[2] = '{1, 19'h7FFE1, 1'b0, 19'h0,     0, 0, 3, 19'h00002, 5'd1,  5'd31, 1'b1, 19'h00003, 19'h00003, 32'd3, 1'b0};
    vecs[3] = '{2, 19'h00210, 1'b1, 19'h00040, 0, 0, 0, 19'h00003, 5'd16, 5'd1,  1'b0, 19'h00004, 19'h00040, 32'd4, 1'b0};
    vecs[4] = '{1, 19'h12345, 1'b0, 19'h0,     4, 1, 0, 19'h00040, 5'd5,  5'd17, 1'b0, 19'h00041, 19'h00041, 32'd5, 1'b0};
    vecs[5] = '{3, 19'h0001C, 1'b1, 19'h7FFFF, 0, 0, 0, 19'h00041, 5'd28, 5'd0,  1'b0, 19'h00042, 19'h7FFFF, 32'd6, 1'b0};
    vecs[6] = '{1, 19'h40000, 1'b0, 19'h0,     0, 0, 0, 19'h7FFFF, 5'd0,  5'd0,  1'b1, 19'h00000, 19'h00000, 32'd7, 1'b0};
    vecs[7] = '{1, 19'h0001F, 1'b0, 19'h0,     0, 0, 0, 19'h00000, 5'd31, 5'd0,  1'b0, 19'h00001, 19'h00001, 32'd8, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("rst_pc", {13'd0, pc}, 32'd0);
    checkOutput("rst_instr", {13'd0, instr}, 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    reqSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) reqSeen++;
    end
    checkOutput("halt_no_req", reqSeen, 0);
    checkOutput("halt_no_err", {31'd0, fetch_err}, 32'd0);
    checkOutput("halt_sticky", {31'd0, halted}, 32'd1);

    // Asynchronous reset out of HALT clears the sticky state immediately.
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_pc", {13'd0, pc}, 32'd0);
    checkOutput("arst_halted", {31'd0, halted}, 32'd0);
    checkOutput("arst_instret", instret, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    one = '{1, 19'h0001C, 1'b0, 19'h0, 0, 0, 0, 19'h00000, 5'd28, 5'd0, 1'b0, 19'h00001, 19'h00001, 32'd1, 1'b0};
    applyStimulus(one);

    // Now in FETCH for address 1; step into WAIT and reset mid-wait.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("wrst_pc", {13'd0, pc}, 32'd0);
    checkOutput("wrst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("wrst_instret", instret, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("idle_no_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    checkOutput("refetch_req", {31'd0, imem_req}, 32'd1);
    checkOutput("refetch_addr", {13'd0, imem_addr}, 32'd0);

    // Leave the request unanswered and watch the timeout fire on the 15th WAIT cycle.
    repeat (15) @(negedge clk);
    checkOutput("tmo_not_yet", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    checkOutput("tmo_err", {31'd0, fetch_err}, 32'd1);
    checkOutput("tmo_halted", {31'd0, halted}, 32'd1);
    imem_valid = 1'b1;
    imem_rdata = 19'h15555;
    @(negedge clk);
    imem_valid = 1'b0;
    reqSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) reqSeen++;
    end
    checkOutput("tmo_no_req", reqSeen, 0);
    checkOutput("tmo_instr_kept", {13'd0, instr}, 32'd0);
    checkOutput("tmo_err_sticky", {31'd0, fetch_err}, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
